// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX operand-select stage and the ALU:
//   - alu_op_e    : 4-bit ALU operation codes (the ALU decodes these too)
//   - alu_class_e : 2-bit main-control operation class from ID
//   - FUNCT_*     : R-type function field codes
//   - decode_alu_op() : class + funct -> ALU op, ALU_INV for anything unknown
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_INV = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_ADD     = 2'b00,
    CLS_SUB     = 2'b01,
    CLS_RTYPE   = 2'b10,
    CLS_ILLEGAL = 2'b11
  } alu_class_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Map an operation class and R-type funct onto an ALU op.
  // Unknown funct values and the illegal class both yield ALU_INV, which the
  // stage reports as an illegal instruction.
  function automatic logic [3:0] decode_alu_op(input logic [1:0] cls,
                                               input logic [5:0] funct);
    logic [3:0] op_s;
    op_s = ALU_INV;
    case (alu_class_e'(cls))
      CLS_ADD: op_s = ALU_ADD;
      CLS_SUB: op_s = ALU_SUB;
      CLS_RTYPE: begin
        case (funct)
          FUNCT_ADD: op_s = ALU_ADD;
          FUNCT_SUB: op_s = ALU_SUB;
          FUNCT_AND: op_s = ALU_AND;
          FUNCT_OR:  op_s = ALU_OR;
          FUNCT_NOR: op_s = ALU_NOR;
          FUNCT_SLT: op_s = ALU_SLT;
          default:   op_s = ALU_INV;
        endcase
      end
      default: op_s = ALU_INV;
    endcase
    return op_s;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Pipeline bus between ID, the ID/EX stage and the ALU.
//   ID side  : in_valid / in_ready handshake plus decoded instruction fields
//   ALU side : out_valid / out_ready handshake plus op, operands and wb tags
// Modports:
//   master : the surroundings (ID producer and ALU consumer)
//   slave  : the id_ex_stage itself
// DWIDTH / RWIDTH must match the parameters of the connected id_ex_stage.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) ();

  // ID -> stage
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_aluop;
  logic [5:0]        in_funct;
  logic              in_alusrc;
  logic [DWIDTH-1:0] in_rs_data;
  logic [DWIDTH-1:0] in_rt_data;
  logic [DWIDTH-1:0] in_imm;
  logic [RWIDTH-1:0] in_rs_idx;
  logic [RWIDTH-1:0] in_rt_idx;
  logic [RWIDTH-1:0] in_wb_idx;
  logic              in_regwrite;

  // stage -> ALU
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        alu_op;
  logic [DWIDTH-1:0] alu_rs1;
  logic [DWIDTH-1:0] alu_rs2;
  logic [DWIDTH-1:0] store_data;
  logic [RWIDTH-1:0] wb_idx;
  logic              wb_regwrite;
  logic              illegal;

  modport master (
    output in_valid, in_aluop, in_funct, in_alusrc, in_rs_data, in_rt_data,
           in_imm, in_rs_idx, in_rt_idx, in_wb_idx, in_regwrite, out_ready,
    input  in_ready, out_valid, alu_op, alu_rs1, alu_rs2, store_data,
           wb_idx, wb_regwrite, illegal
  );

  modport slave (
    input  in_valid, in_aluop, in_funct, in_alusrc, in_rs_data, in_rt_data,
           in_imm, in_rs_idx, in_rt_idx, in_wb_idx, in_regwrite, out_ready,
    output in_ready, out_valid, alu_op, alu_rs1, alu_rs2, store_data,
           wb_idx, wb_regwrite, illegal
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Single-operand forwarding selector.
//   src_idx / rf_data          : operand index and register-file value
//   exmem_* / memwb_*          : the two in-flight producers
//   fwd_data                   : value the operand should actually use
// EX/MEM is the younger producer and therefore wins over MEM/WB.
// Register 0 is hardwired, so a producer targeting it is never forwarded.
// ---------------------------------------------------------------------------
module fwd_mux #(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic [RWIDTH-1:0] src_idx,
  input  logic [DWIDTH-1:0] rf_data,
  input  logic              exmem_regwrite,
  input  logic [RWIDTH-1:0] exmem_rd,
  input  logic [DWIDTH-1:0] exmem_data,
  input  logic              memwb_regwrite,
  input  logic [RWIDTH-1:0] memwb_rd,
  input  logic [DWIDTH-1:0] memwb_data,
  output logic [DWIDTH-1:0] fwd_data
);

  logic exmem_hit_s;
  logic memwb_hit_s;

  assign exmem_hit_s = exmem_regwrite && (exmem_rd != {RWIDTH{1'b0}}) &&
                       (exmem_rd == src_idx);
  assign memwb_hit_s = memwb_regwrite && (memwb_rd != {RWIDTH{1'b0}}) &&
                       (memwb_rd == src_idx);

  // Priority select: youngest matching producer, else register file.
  always_comb begin
    fwd_data = rf_data;
    if (exmem_hit_s) begin
      fwd_data = exmem_data;
    end else if (memwb_hit_s) begin
      fwd_data = memwb_data;
    end else begin
      fwd_data = rf_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register and ALU operand select.
// Ports:
//   clk, rstn      : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : ID handshake + fields in, ALU handshake + op/operands out
//   flush          : squash the held instruction and refuse this cycle's input
//   exmem_*        : EX/MEM forwarding source (regwrite, rd, data)
//   memwb_*        : MEM/WB forwarding source (regwrite, rd, data)
// The instruction fields are registered; decode and forwarding are
// combinational on the registered fields so that a stalled instruction keeps
// picking up producers that retire while it waits.
// alu_op reads ALU_INV whenever no instruction is held.
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int RWIDTH = 5
) (
  input  logic              clk,
  input  logic              rstn,
  id_ex_stage_if.slave      bus,
  input  logic              flush,
  input  logic              exmem_regwrite,
  input  logic [RWIDTH-1:0] exmem_rd,
  input  logic [DWIDTH-1:0] exmem_data,
  input  logic              memwb_regwrite,
  input  logic [RWIDTH-1:0] memwb_rd,
  input  logic [DWIDTH-1:0] memwb_data
);

  logic              valid_r;
  logic [1:0]        aluop_r;
  logic [5:0]        funct_r;
  logic              alusrc_r;
  logic [DWIDTH-1:0] rs_data_r;
  logic [DWIDTH-1:0] rt_data_r;
  logic [DWIDTH-1:0] imm_r;
  logic [RWIDTH-1:0] rs_idx_r;
  logic [RWIDTH-1:0] rt_idx_r;
  logic [RWIDTH-1:0] wb_idx_r;
  logic              regwrite_r;

  logic              in_ready_s;
  logic              load_s;
  logic [3:0]        decoded_op_s;
  logic [DWIDTH-1:0] rs_fwd_s;
  logic [DWIDTH-1:0] rt_fwd_s;

  // The slot frees up when empty or when the ALU takes the current entry.
  // in_ready ignores flush on purpose: ID is squashed by the same flush.
  assign in_ready_s = !valid_r || bus.out_ready;
  assign load_s     = bus.in_valid && in_ready_s && !flush;

  // Occupancy: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Instruction field capture; fields only change on an accepted load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aluop_r    <= 2'b00;
      funct_r    <= 6'b000000;
      alusrc_r   <= 1'b0;
      rs_data_r  <= {DWIDTH{1'b0}};
      rt_data_r  <= {DWIDTH{1'b0}};
      imm_r      <= {DWIDTH{1'b0}};
      rs_idx_r   <= {RWIDTH{1'b0}};
      rt_idx_r   <= {RWIDTH{1'b0}};
      wb_idx_r   <= {RWIDTH{1'b0}};
      regwrite_r <= 1'b0;
    end else if (load_s) begin
      aluop_r    <= bus.in_aluop;
      funct_r    <= bus.in_funct;
      alusrc_r   <= bus.in_alusrc;
      rs_data_r  <= bus.in_rs_data;
      rt_data_r  <= bus.in_rt_data;
      imm_r      <= bus.in_imm;
      rs_idx_r   <= bus.in_rs_idx;
      rt_idx_r   <= bus.in_rt_idx;
      wb_idx_r   <= bus.in_wb_idx;
      regwrite_r <= bus.in_regwrite;
    end else begin
      aluop_r    <= aluop_r;
      funct_r    <= funct_r;
      alusrc_r   <= alusrc_r;
      rs_data_r  <= rs_data_r;
      rt_data_r  <= rt_data_r;
      imm_r      <= imm_r;
      rs_idx_r   <= rs_idx_r;
      rt_idx_r   <= rt_idx_r;
      wb_idx_r   <= wb_idx_r;
      regwrite_r <= regwrite_r;
    end
  end

  fwd_mux #(
    .DWIDTH (DWIDTH),
    .RWIDTH (RWIDTH)
  ) u_fwd_rs (
    .src_idx        (rs_idx_r),
    .rf_data        (rs_data_r),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_data     (exmem_data),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .fwd_data       (rs_fwd_s)
  );

  fwd_mux #(
    .DWIDTH (DWIDTH),
    .RWIDTH (RWIDTH)
  ) u_fwd_rt (
    .src_idx        (rt_idx_r),
    .rf_data        (rt_data_r),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_data     (exmem_data),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data),
    .fwd_data       (rt_fwd_s)
  );

  assign decoded_op_s = decode_alu_op(aluop_r, funct_r);

  // ALU op and illegal flag; an empty slot presents ALU_INV without raising illegal.
  always_comb begin
    bus.alu_op  = ALU_INV;
    bus.illegal = 1'b0;
    if (valid_r) begin
      bus.alu_op  = decoded_op_s;
      bus.illegal = (decoded_op_s == ALU_INV);
    end else begin
      bus.alu_op  = ALU_INV;
      bus.illegal = 1'b0;
    end
  end

  // Operand 2 is the immediate for I-type forms, otherwise the forwarded rt.
  always_comb begin
    bus.alu_rs2 = rt_fwd_s;
    if (alusrc_r) begin
      bus.alu_rs2 = imm_r;
    end else begin
      bus.alu_rs2 = rt_fwd_s;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = valid_r;
  assign bus.alu_rs1     = rs_fwd_s;
  assign bus.store_data  = rt_fwd_s;
  assign bus.wb_idx      = wb_idx_r;
  assign bus.wb_regwrite = regwrite_r && valid_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: an instruction-level model of the stage
// (one slot, captured instruction, forwarding lookup, decode table) checked
// against the DUT on every falling edge, plus hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          flush = 1'b0;
  logic          exmem_regwrite = 1'b0;
  logic [RW-1:0] exmem_rd = '0;
  logic [DW-1:0] exmem_data = '0;
  logic          memwb_regwrite = 1'b0;
  logic [RW-1:0] memwb_rd = '0;
  logic [DW-1:0] memwb_data = '0;

  id_ex_stage_if #(.DWIDTH(DW), .RWIDTH(RW)) bus ();

  id_ex_stage #(.DWIDTH(DW), .RWIDTH(RW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .bus            (bus.slave),
    .flush          (flush),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_data     (exmem_data),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_data     (memwb_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  cls;
    logic [5:0]  fn;
    logic        src;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  rsi;
    logic [4:0]  rti;
    logic [4:0]  wbi;
    logic        rw;
  } instr_t;

  logic   m_valid;
  instr_t m_ins;

  function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx != 5'd0 && exmem_regwrite && exmem_rd == idx) return exmem_data;
    if (idx != 5'd0 && memwb_regwrite && memwb_rd == idx) return memwb_data;
    return rf;
  endfunction

  function automatic logic [3:0] m_op(input logic [1:0] cls, input logic [5:0] fn);
    logic [5:0] fns [6];
    logic [3:0] ops [6];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    ops = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7};
    if (cls == 2'd0) return 4'h2;
    if (cls == 2'd1) return 4'h6;
    if (cls == 2'd2) begin
      for (int i = 0; i < 6; i++) if (fns[i] == fn) return ops[i];
    end
    return 4'hF;
  endfunction

  // Slot model: flush empties, an accepted offer fills, a taken entry leaves.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_ins   <= '{default: '0};
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
      m_valid <= 1'b1;
      m_ins   <= '{bus.in_aluop, bus.in_funct, bus.in_alusrc, bus.in_rs_data,
                   bus.in_rt_data, bus.in_imm, bus.in_rs_idx, bus.in_rt_idx,
                   bus.in_wb_idx, bus.in_regwrite};
    end else if (bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rstn) begin
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      check("wb_regwrite", 32'(bus.wb_regwrite), 32'(m_valid && m_ins.rw));
      check("wb_idx", 32'(bus.wb_idx), 32'(m_ins.wbi));
      check("illegal", 32'(bus.illegal), 32'(m_valid && m_op(m_ins.cls, m_ins.fn) == 4'hF));
      if (m_valid) begin
        check("alu_op", 32'(bus.alu_op), 32'(m_op(m_ins.cls, m_ins.fn)));
        check("alu_rs1", bus.alu_rs1, m_fwd(m_ins.rsi, m_ins.rs));
        check("alu_rs2", bus.alu_rs2, m_ins.src ? m_ins.imm : m_fwd(m_ins.rti, m_ins.rt));
        check("store_data", bus.store_data, m_fwd(m_ins.rti, m_ins.rt));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.in_valid   = 1'b0;
    flush          = 1'b0;
    exmem_regwrite = 1'b0;
    memwb_regwrite = 1'b0;
    exmem_rd       = '0;
    memwb_rd       = '0;
  endtask

  task automatic offer(input logic [1:0] cls, input logic [5:0] fn, input logic src,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic [4:0] rsi, input logic [4:0] rti, input logic [4:0] wbi,
                       input logic rw);
    bus.in_valid    = 1'b1;
    bus.in_aluop    = cls;
    bus.in_funct    = fn;
    bus.in_alusrc   = src;
    bus.in_rs_data  = rs;
    bus.in_rt_data  = rt;
    bus.in_imm      = imm;
    bus.in_rs_idx   = rsi;
    bus.in_rt_idx   = rti;
    bus.in_wb_idx   = wbi;
    bus.in_regwrite = rw;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    offer(2'd0, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.in_valid = 1'b0;

    // Reset state
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'hF);
    check("rst_wb_regwrite", 32'(bus.wb_regwrite), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // R-type sub, no forwarding
    offer(2'b10, 6'b100010, 1'b0, 32'd7, 32'd3, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1);
    step();
    bus.in_valid = 1'b0;
    check("sub_valid", 32'(bus.out_valid), 32'd1);
    check("sub_op", 32'(bus.alu_op), 32'h6);
    check("sub_rs1", bus.alu_rs1, 32'd7);
    check("sub_rs2", bus.alu_rs2, 32'd3);
    check("sub_wbrw", 32'(bus.wb_regwrite), 32'd1);
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Forwarding priority
    offer(2'b10, 6'b100000, 1'b0, 32'h11, 32'h22, 32'd0, 5'd5, 5'd6, 5'd7, 1'b1);
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_data = 32'hAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hBB;
    step();
    bus.in_valid = 1'b0;
    check("fwd_exmem", bus.alu_rs1, 32'hAA);
    exmem_regwrite = 1'b0;
    #1;
    check("fwd_memwb", bus.alu_rs1, 32'hBB);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    check("fwd_zero", bus.alu_rs1, 32'h11);
    check("fwd_zero_rt", bus.alu_rs2, 32'h22);
    quiet();
    step();

    // Stall with a new offer waiting; late producer for rt
    offer(2'b00, 6'd0, 1'b0, 32'd100, 32'd200, 32'd0, 5'd4, 5'd9, 5'd12, 1'b1);
    step();
    bus.out_ready = 1'b0;
    offer(2'b01, 6'd0, 1'b0, 32'd300, 32'd400, 32'd0, 5'd1, 5'd2, 5'd13, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_rs1", bus.alu_rs1, 32'd100);
      check("stall_wbidx", 32'(bus.wb_idx), 32'd12);
      if (i == 1) begin
        memwb_regwrite = 1'b1; memwb_rd = 5'd9; memwb_data = 32'h1234;
        #1;
        check("stall_late_rs2", bus.alu_rs2, 32'h1234);
        check("stall_late_st", bus.store_data, 32'h1234);
      end
    end
    bus.out_ready = 1'b1;
    memwb_regwrite = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("after_stall_op", 32'(bus.alu_op), 32'h6);
    check("after_stall_rs1", bus.alu_rs1, 32'd300);
    check("after_stall_rs2", bus.alu_rs2, 32'd400);
    check("after_stall_wbidx", 32'(bus.wb_idx), 32'd13);
    quiet();
    step();

    // Flush collides with a held instruction and a new offer
    offer(2'b00, 6'd0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd3, 5'd4, 5'd5, 1'b1);
    step();
    bus.out_ready = 1'b0;
    offer(2'b00, 6'd0, 1'b1, 32'd0, 32'd0, 32'h10, 5'd1, 5'd1, 5'd8, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_wbrw", 32'(bus.wb_regwrite), 32'd0);
    quiet();
    bus.out_ready = 1'b1;
    step();

    // Illegal decode and immediate select
    offer(2'b10, 6'b000111, 1'b0, 32'd9, 32'd9, 32'd0, 5'd2, 5'd3, 5'd1, 1'b1);
    step();
    check("ill_op", 32'(bus.alu_op), 32'hF);
    check("ill_flag", 32'(bus.illegal), 32'd1);
    offer(2'b00, 6'd0, 1'b1, 32'd5, 32'd6, 32'hFFFFFFFC, 5'd2, 5'd3, 5'd4, 1'b1);
    step();
    check("imm_op", 32'(bus.alu_op), 32'h2);
    check("imm_rs2", bus.alu_rs2, 32'hFFFFFFFC);
    check("imm_store", bus.store_data, 32'd6);
    check("imm_illegal", 32'(bus.illegal), 32'd0);
    offer(2'b11, 6'b100000, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1, 5'd1, 5'd1, 1'b0);
    step();
    check("cls11_illegal", 32'(bus.illegal), 32'd1);
    quiet();
    step();

    // Back-to-back decode sweep with random data, forwarding and backpressure
    for (int i = 0; i < 24; i++) begin
      logic [5:0] fn_tab [8];
      fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F, 6'h00};
      offer(2'($urandom_range(0, 3)), fn_tab[i % 8], 1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom), 1'($urandom_range(0, 1)));
      bus.in_valid   = 1'($urandom_range(0, 3) != 0);
      bus.out_ready  = 1'($urandom_range(0, 3) != 0);
      exmem_regwrite = 1'($urandom_range(0, 1));
      exmem_rd       = 5'($urandom_range(0, 7));
      exmem_data     = $urandom;
      memwb_regwrite = 1'($urandom_range(0, 1));
      memwb_rd       = 5'($urandom_range(0, 7));
      memwb_data     = $urandom;
      flush          = 1'($urandom_range(0, 7) == 0);
      step();
    end
    quiet();
    bus.out_ready = 1'b1;
    step();

    // Asynchronous reset while holding a valid instruction
    offer(2'b10, 6'b100100, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1);
    step();
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_op", 32'(bus.alu_op), 32'h0);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_op", 32'(bus.alu_op), 32'hF);
    check("async_rst_wbrw", 32'(bus.wb_regwrite), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
